// File: rtl/shift_arbiter_pkg.sv
// Shared processor definitions: shift-type codes and arbiter state encoding.
// Imported by the shifter datapath and the two-requester shift arbiter.
package shift_arbiter_pkg;

  localparam logic [3:0] SH_SRL = 4'b1000;
  localparam logic [3:0] SH_SLL = 4'b1001;
  localparam logic [3:0] SH_SRA = 4'b1010;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational 32-bit shifter: logical right/left, arithmetic right, or pass-through.
// Unrecognised type codes return the operand untouched.
module shifter
  import shift_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic [3:0]  type_sel,
  output logic [31:0] r
);

  always_comb begin
    r = a;
    case (type_sel)
      SH_SRL:  r = a >> shamt;
      SH_SLL:  r = a << shamt;
      SH_SRA:  r = $unsigned($signed(a) >>> shamt);
      default: r = a;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of one shared shifter, with a
// single registered result slot that can be refilled in the same cycle it drains.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [4:0]       req0_shamt,
  input  logic [3:0]       req0_type,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [4:0]       req1_shamt,
  input  logic [3:0]       req1_type,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag
);

  logic             state_reg, state_next;
  logic             rr_reg;
  logic             acc;
  logic             grant0, grant1, any_grant;
  logic [31:0]      mux_a;
  logic [4:0]       mux_shamt;
  logic [3:0]       mux_type;
  logic [TAG_W-1:0] mux_tag;
  logic [31:0]      shift_r;
  logic [31:0]      res_data_reg;
  logic             res_src_reg;
  logic [TAG_W-1:0] res_tag_reg;

  // Readies are forced low while reset is asserted so nothing is consumed.
  assign acc       = ~rst & ((state_reg == ST_IDLE) | res_ready);
  assign grant0    = req0_valid & (~req1_valid | (rr_reg == 1'b0));
  assign grant1    = req1_valid & (~req0_valid | (rr_reg == 1'b1));
  assign any_grant = acc & (grant0 | grant1);

  assign mux_a     = grant1 ? req1_a     : req0_a;
  assign mux_shamt = grant1 ? req1_shamt : req0_shamt;
  assign mux_type  = grant1 ? req1_type  : req0_type;
  assign mux_tag   = grant1 ? req1_tag   : req0_tag;

  shifter u_shifter (
    .a        (mux_a),
    .shamt    (mux_shamt),
    .type_sel (mux_type),
    .r        (shift_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (any_grant) begin
      state_next = ST_HOLD;
    end else if ((state_reg == ST_HOLD) && res_ready) begin
      state_next = ST_IDLE;
    end
  end

  always_comb begin
    res_valid  = (state_reg == ST_HOLD);
    req0_ready = acc & grant0;
    req1_ready = acc & grant1;
  end

  // Pointer moves to the loser so a waiting requester wins the next contest.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg       <= 1'b0;
      res_data_reg <= '0;
      res_src_reg  <= 1'b0;
      res_tag_reg  <= '0;
    end else if (any_grant) begin
      rr_reg       <= ~grant1;
      res_data_reg <= shift_r;
      res_src_reg  <= grant1;
      res_tag_reg  <= mux_tag;
    end
  end

  assign res_data = res_data_reg;
  assign res_src  = res_src_reg;
  assign res_tag  = res_tag_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed-vector bench for shift_arbiter: reset, shift types, round-robin
// alternation, backpressure hold, and reset during a held result.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req1_a;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [3:0]  req0_type, req1_type;
  logic [3:0]  req0_tag, req1_tag;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_src;
  logic [3:0]  res_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_shamt (req0_shamt),
    .req0_type  (req0_type),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_shamt (req1_shamt),
    .req1_type  (req1_type),
    .req1_tag   (req1_tag),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_src    (res_src),
    .res_tag    (res_tag)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [31:0] a,
                         input logic [4:0] sh, input logic [3:0] ty, input logic [3:0] tg);
    if (idx == 0) begin
      req0_valid = v; req0_a = a; req0_shamt = sh; req0_type = ty; req0_tag = tg;
    end else begin
      req1_valid = v; req1_a = a; req1_shamt = sh; req1_type = ty; req1_tag = tg;
    end
  endtask

  // One line per accepted operation and per consumed result.
  always @(negedge clk) begin
    if (req0_ready || req1_ready)
      $display("accept src=%0d t=%0t", req1_ready, $time);
    if (res_valid && res_ready)
      $display("result src=%0d tag=%0d data=0x%08h t=%0t", res_src, res_tag, res_data, $time);
  end

  initial begin
    rst = 1'b1;
    res_ready = 1'b0;
    set_req(0, 1'b0, 32'h0, 5'd0, 4'h0, 4'h0);
    set_req(1, 1'b0, 32'h0, 5'd0, 4'h0, 4'h0);
    tick;
    req0_valid = 1'b1;
    #1;
    check_eq("rst_ready0", {31'b0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    check_eq("rst_valid", {31'b0, res_valid}, 32'd0);
    check_eq("rst_data",  res_data, 32'h0);
    check_eq("rst_src",   {31'b0, res_src}, 32'd0);
    check_eq("rst_tag",   {28'b0, res_tag}, 32'd0);

    // Single request, arithmetic right of a negative value.
    set_req(0, 1'b1, 32'h8000_0000, 5'd4, 4'b1010, 4'd3);
    #1;
    check_eq("sra_ready0", {31'b0, req0_ready}, 32'd1);
    check_eq("sra_ready1", {31'b0, req1_ready}, 32'd0);
    tick;
    req0_valid = 1'b0;
    check_eq("sra_valid", {31'b0, res_valid}, 32'd1);
    check_eq("sra_data",  res_data, 32'hF800_0000);
    check_eq("sra_src",   {31'b0, res_src}, 32'd0);
    check_eq("sra_tag",   {28'b0, res_tag}, 32'd3);
    res_ready = 1'b1;
    tick;
    check_eq("drain_idle", {31'b0, res_valid}, 32'd0);

    // Both valid every cycle; pointer now favours requester 1.
    set_req(0, 1'b1, 32'h0000_0010, 5'd1, 4'b1001, 4'd1);
    set_req(1, 1'b1, 32'h0000_0100, 5'd4, 4'b1000, 4'd2);
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2 == 0);
      #1;
      check_eq("rr_ready0", {31'b0, req0_ready}, {31'b0, ~g});
      check_eq("rr_ready1", {31'b0, req1_ready}, {31'b0, g});
      tick;
      check_eq("rr_valid", {31'b0, res_valid}, 32'd1);
      check_eq("rr_src",   {31'b0, res_src}, {31'b0, g});
      check_eq("rr_tag",   {28'b0, res_tag}, g ? 32'd2 : 32'd1);
      check_eq("rr_data",  res_data, g ? 32'h0000_0010 : 32'h0000_0020);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick;
    check_eq("rr_idle", {31'b0, res_valid}, 32'd0);
    res_ready = 1'b0;

    // Pass-through type code, then backpressure while requester 1 waits.
    set_req(0, 1'b1, 32'hDEAD_BEEF, 5'd7, 4'b0000, 4'd5);
    tick;
    req0_valid = 1'b0;
    check_eq("pass_data", res_data, 32'hDEAD_BEEF);
    set_req(1, 1'b1, 32'h0000_0001, 5'd31, 4'b1001, 4'd9);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("hold_ready1", {31'b0, req1_ready}, 32'd0);
      check_eq("hold_valid",  {31'b0, res_valid}, 32'd1);
      check_eq("hold_data",   res_data, 32'hDEAD_BEEF);
      check_eq("hold_tag",    {28'b0, res_tag}, 32'd5);
      tick;
    end
    res_ready = 1'b1;
    #1;
    check_eq("release_ready1", {31'b0, req1_ready}, 32'd1);
    tick;
    check_eq("sll_data", res_data, 32'h8000_0000);
    check_eq("sll_src",  {31'b0, res_src}, 32'd1);
    check_eq("sll_tag",  {28'b0, res_tag}, 32'd9);

    // Back-to-back refills from HOLD.
    set_req(1, 1'b1, 32'hFFFF_FFFF, 5'd31, 4'b1000, 4'd4);
    #1;
    check_eq("srl_ready1", {31'b0, req1_ready}, 32'd1);
    tick;
    req1_valid = 1'b0;
    check_eq("srl_data", res_data, 32'h0000_0001);
    set_req(0, 1'b1, 32'h8000_0000, 5'd0, 4'b1010, 4'd6);
    tick;
    check_eq("sh0_data", res_data, 32'h8000_0000);
    set_req(0, 1'b1, 32'h7000_0000, 5'd4, 4'b1010, 4'd7);
    tick;
    req0_valid = 1'b0;
    check_eq("srapos_data", res_data, 32'h0700_0000);
    check_eq("srapos_valid", {31'b0, res_valid}, 32'd1);

    // Reset during HOLD with both requesters pending; pointer was at 1.
    res_ready = 1'b0;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_eq("rsthold_ready0", {31'b0, req0_ready}, 32'd0);
    check_eq("rsthold_ready1", {31'b0, req1_ready}, 32'd0);
    tick;
    rst = 1'b0;
    check_eq("rsthold_valid", {31'b0, res_valid}, 32'd0);
    check_eq("rsthold_data",  res_data, 32'h0);
    #1;
    check_eq("post_rst_ready0", {31'b0, req0_ready}, 32'd1);
    check_eq("post_rst_ready1", {31'b0, req1_ready}, 32'd0);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("post_rst_src",  {31'b0, res_src}, 32'd0);
    check_eq("post_rst_data", res_data, 32'h0700_0000);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: TAG_W, default 4, width of the requester tag carried through with each operation.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a / req0_shamt / req0_type / req0_tag  input  32/5/4/TAG_W  requester 0 operand, shift amount, shift type, tag.
REQ-007 req1_valid, req1_ready, req1_a, req1_shamt, req1_type, req1_tag  same widths and meaning for requester 1.
REQ-008 res_valid  output  1  registered result available.
REQ-009 res_ready  input  1  consumer accepts the result this cycle.
REQ-010 res_data  output  32  shifted result.
REQ-011 res_src  output  1  index of the requester that produced res_data.
REQ-012 res_tag  output  TAG_W  tag of the producing operation.

Function
REQ-013 Type encoding: 4'b1000 logical right, 4'b1001 logical left, 4'b1010 arithmetic right (sign-fill from bit 31), any other value passes a through unchanged.
REQ-014 shamt is 5 bits unsigned (0..31); shamt 0 returns a unchanged for every type.
REQ-015 Two states: IDLE (res_valid=0) and HOLD (res_valid=1).
REQ-016 Accept condition: acc = (state==IDLE) | res_ready.
REQ-017 Grant: when acc is high and exactly one valid, grant that requester; both valid, grant the requester selected by the round-robin pointer rr.
REQ-018 reqN_ready = acc & grantN, combinational, same cycle; at most one ready high per cycle; ready never high while its valid is low.
REQ-019 On a grant: the granted operands are muxed into one shared shift datapath, and res_data, res_src and res_tag are registered at the next edge; state becomes HOLD; latency is one cycle from the accept edge to res_valid.
REQ-020 On a grant, rr is set to the non-granted requester; with no grant, rr holds.
REQ-021 HOLD with res_ready=0: res_valid, res_data, res_src and res_tag remain stable; both readies are 0.
REQ-022 HOLD with res_ready=1 and no valid request: the next state is IDLE.
REQ-023 HOLD with res_ready=1 and a valid request: the new request is accepted in the same cycle, state stays HOLD, and sustained throughput is one operation per cycle.
REQ-024 Starvation bound: a requester holding valid high is granted within two accepts.
REQ-025 Requesters must hold operands stable while valid=1 and ready=0; the block does not sample operands otherwise.

Reset
REQ-026 While rst=1 at a clock edge: state becomes IDLE, res_valid=0, res_data=0, res_src=0, res_tag=0, rr=0 (requester 0 favoured first).
REQ-027 A reset asserted during HOLD discards the held result without a handshake; req0_ready and req1_ready are 0 during any cycle in which rst=1.

Structure
REQ-028 Shift-type codes (SRL, SLL, SRA) and the state encoding shall be localparams in the shared processor package.
REQ-029 The shift datapath shall be one instance of the existing combinational sub-module shifter (a, shamt, type -> r), fed by the grant mux.
REQ-030 No other sub-modules; the FSM, the round-robin pointer and the output register are local to shift_arbiter.

Verification
REQ-031 After reset, only req0 valid with a=0x80000000, shamt=4, type=1010 -> req0_ready=1 that cycle; next cycle res_valid=1, res_data=0xF8000000, res_src=0.
REQ-032 Both valid every cycle with res_ready=1 -> grants alternate 0,1,0,1; one result per cycle; res_src and res_tag match the grant order.
REQ-033 res_ready=0 for 5 cycles while HOLD, req1 valid with a=0x1, shamt=31, type=1001 -> res_data stable and req1_ready=0 throughout; on the cycle res_ready rises, req1 is accepted and res_data=0x80000000 the next cycle.
REQ-034 type=4'b0000, a=0xDEADBEEF, shamt=7 -> res_data=0xDEADBEEF; type=1000, a=0xFFFFFFFF, shamt=31 -> res_data=0x00000001.
REQ-035 rst asserted for 1 cycle while in HOLD -> next cycle res_valid=0, res_data=0, rr=0; with both valid after reset, req0 is granted first.
